// File: rtl/xor_pkg.sv
// Shared definitions for the XOR cipher packer: FSM states and byte width.
package xor_pkg;

  localparam int largura_byte = 8;

  typedef enum logic [1:0] {
    COLETA,
    INICIA,
    AGUARDA,
    LIBERA
  } estado_t;

endpackage

// File: rtl/empacotador_xor_contador_espera.sv
// Wait counter for the cipher handshake: counts while enabled, clears otherwise,
// and flags when the current cycle is the last one allowed before a timeout.
module contador_espera #(
  parameter int limite  = 64,
  parameter int largura = $clog2(limite + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic conta,
  output logic atingiu
);

  logic [largura-1:0] contagem_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      contagem_reg <= '0;
    end else if (!conta) begin
      contagem_reg <= '0;
    end else if (contagem_reg != largura'(limite)) begin
      contagem_reg <= contagem_reg + 1'b1;
    end
  end

  // The cycle holding limite-1 is the limite-th waiting cycle.
  assign atingiu = (contagem_reg >= largura'(limite - 1));

endmodule

// File: rtl/empacotador_xor.sv
// Packs an MSB-first byte stream into words, latches a key and hands both to a
// cipher stage through a level-held start/done handshake with timeout.
module empacotador_xor
  import xor_pkg::*;
#(
  parameter int tamanho_palavra = 16,
  parameter int tamanho_key     = 8,
  parameter int limite_espera   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic                       key_load,
  input  logic [tamanho_key-1:0]     key_in,
  output logic [tamanho_palavra-1:0] plaintext,
  output logic [tamanho_key-1:0]     key,
  output logic                       start,
  input  logic                       done,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int num_bytes    = tamanho_palavra / largura_byte;
  localparam int largura_cont = $clog2(num_bytes + 1);

  estado_t                  estado_reg, estado_next;
  logic [largura_cont-1:0]  byte_cnt_reg;
  logic [largura_byte-1:0]  byte_reg [num_bytes];
  logic [tamanho_key-1:0]   key_reg;
  logic                     start_reg, busy_reg, in_ready_reg, timeout_err_reg;
  logic                     aceita, ultimo, atingiu, seta_timeout, conta_espera;

  assign aceita       = in_valid && (estado_reg == COLETA);
  assign ultimo       = aceita && (byte_cnt_reg == largura_cont'(num_bytes - 1));
  assign conta_espera = (estado_reg == INICIA) || (estado_reg == AGUARDA);

  contador_espera #(.limite(limite_espera)) u_contador_espera (
    .clk     (clk),
    .reset   (reset),
    .conta   (conta_espera),
    .atingiu (atingiu)
  );

  always_comb begin
    estado_next  = estado_reg;
    seta_timeout = 1'b0;
    case (estado_reg)
      COLETA:  if (ultimo) estado_next = INICIA;
      INICIA:  estado_next = AGUARDA;
      AGUARDA: begin
        if (done) begin
          estado_next = LIBERA;
        end else if (atingiu) begin
          estado_next  = LIBERA;
          seta_timeout = 1'b1;
        end
      end
      LIBERA:  if (!done) estado_next = COLETA;
      default: estado_next = COLETA;
    endcase
  end

  // Handshake outputs are decoded from the next state so they stay registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_reg      <= COLETA;
      byte_cnt_reg    <= '0;
      key_reg         <= '0;
      start_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      in_ready_reg    <= 1'b1;
      timeout_err_reg <= 1'b0;
    end else begin
      estado_reg      <= estado_next;
      start_reg       <= (estado_next == INICIA) || (estado_next == AGUARDA);
      busy_reg        <= (estado_next != COLETA);
      in_ready_reg    <= (estado_next == COLETA);
      timeout_err_reg <= timeout_err_reg | seta_timeout;
      if (ultimo) begin
        byte_cnt_reg <= '0;
      end else if (aceita) begin
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
      end
      if (key_load && (estado_reg == COLETA)) begin
        key_reg <= key_in;
      end
    end
  end

  for (genvar gi = 0; gi < num_bytes; gi++) begin : g_byte
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        byte_reg[gi] <= '0;
      end else if (aceita && (byte_cnt_reg == largura_cont'(gi))) begin
        byte_reg[gi] <= in_data;
      end
    end
    assign plaintext[tamanho_palavra-1-gi*largura_byte -: largura_byte] = byte_reg[gi];
  end

  assign key         = key_reg;
  assign start       = start_reg;
  assign busy        = busy_reg;
  assign in_ready    = in_ready_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_empacotador_xor.sv
// Self-checking bench for empacotador_xor: directed scenarios, a vector table
// and randomized words checked against a word/key reference model.
module tb_empacotador_xor;

  localparam int W = 16;
  localparam int K = 8;
  localparam int L = 16;
  localparam int N = W / 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = '0;
  logic         key_load = 1'b0;
  logic [K-1:0] key_in = '0;
  logic [W-1:0] plaintext;
  logic [K-1:0] key;
  logic         start;
  logic         done = 1'b0;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int failures = 0;

  empacotador_xor #(.tamanho_palavra(W), .tamanho_key(K), .limite_espera(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .key_load(key_load), .key_in(key_in),
    .plaintext(plaintext), .key(key), .start(start), .done(done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nome, atual, esperado);
    end
  endtask

  // Presents a byte and holds it until the handshake edge; optionally keeps in_valid high.
  task automatic send_byte(input logic [7:0] b, input bit manter);
    int espera;
    in_valid = 1'b1;
    in_data  = b;
    espera   = 0;
    while (!in_ready && espera < 200) begin
      tick();
      espera++;
    end
    if (espera >= 200) chk("in_ready_wait", 32'(in_ready), 1);
    tick();
    if (!manter) in_valid = 1'b0;
  endtask

  // Called right after the last byte (FSM in INICIA): finish the handshake after d cycles.
  task automatic handshake(input int d, input int hold);
    repeat (d) tick();
    done = 1'b1;
    tick();
    chk("hs_start_fall", 32'(start), 0);
    repeat (hold - 1) tick();
    done = 1'b0;
    tick();
    chk("hs_in_ready_back", 32'(in_ready), 1);
  endtask

  typedef struct {
    logic [7:0] b0, b1;
    bit         carrega;
    bit         carrega_ultimo;
    logic [7:0] chave;
    logic [15:0] exp_pt;
    logic [7:0]  exp_key;
  } vetor_t;

  vetor_t tabela [4];
  logic [K-1:0] key_model;
  logic [W-1:0] word_model;
  logic [7:0]   bytes_q [$];

  initial begin
    tabela[0] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'hA5, 16'h1234, 8'hA5};
    tabela[1] = '{8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 16'hFF00, 8'hA5};
    tabela[2] = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'h3C, 16'h00FF, 8'h3C};
    tabela[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h00, 16'h8001, 8'h00};

    // Reset state
    tick(); tick();
    chk("rst_plaintext", 32'(plaintext), 0);
    chk("rst_key", 32'(key), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Scenario 1: basic word with key load
    key_load = 1'b1; key_in = 8'hFF;
    tick();
    key_load = 1'b0;
    send_byte(8'h48, 0);
    chk("s1_start_mid", 32'(start), 0);
    send_byte(8'h48, 0);
    chk("s1_start_rise", 32'(start), 1);
    chk("s1_plaintext", 32'(plaintext), 32'h4848);
    chk("s1_key", 32'(key), 32'hFF);
    chk("s1_busy", 32'(busy), 1);
    chk("s1_in_ready", 32'(in_ready), 0);
    tick();
    chk("s1_start_hold", 32'(start), 1);
    handshake(0, 1);
    chk("s1_busy_idle", 32'(busy), 0);

    // Done in COLETA is ignored
    done = 1'b1;
    tick(); tick();
    chk("idle_done_busy", 32'(busy), 0);
    chk("idle_done_start", 32'(start), 0);
    done = 1'b0;

    // Scenario 2: in_valid held high across two words
    send_byte(8'hB7, 1);
    send_byte(8'hB7, 1);
    in_data = 8'h00;
    chk("s2_word1", 32'(plaintext), 32'hB7B7);
    chk("s2_ready_low", 32'(in_ready), 0);
    tick();
    done = 1'b1;
    tick();
    chk("s2_ready_libera", 32'(in_ready), 0);
    chk("s2_word1_hold", 32'(plaintext), 32'hB7B7);
    done = 1'b0;
    tick();
    send_byte(8'h00, 1);
    send_byte(8'h11, 0);
    chk("s2_word2", 32'(plaintext), 32'h0011);
    handshake(1, 1);

    // Scenario 3: timeout
    send_byte(8'hC3, 0);
    send_byte(8'h3C, 0);
    begin
      int n = 0;
      while (start && n < 100) begin
        n++;
        tick();
      end
      chk("s3_start_cycles", 32'(n), 32'(L));
    end
    chk("s3_timeout_set", 32'(timeout_err), 1);
    chk("s3_start_low", 32'(start), 0);
    tick(); tick();
    chk("s3_back_idle", 32'(in_ready), 1);
    chk("s3_timeout_sticky", 32'(timeout_err), 1);

    // Scenario 4: key_load while busy ignored, then applied in COLETA
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    key_load = 1'b1; key_in = 8'h55;
    tick();
    key_load = 1'b0;
    chk("s4_key_busy", 32'(key), 32'hFF);
    handshake(0, 1);
    chk("s4_timeout_still", 32'(timeout_err), 1);
    key_load = 1'b1; key_in = 8'h55;
    tick();
    key_load = 1'b0;
    chk("s4_key_coleta", 32'(key), 32'h55);

    // Scenario 5: reset mid-word
    send_byte(8'hAA, 0);
    reset = 1'b1;
    #1;
    chk("s5_plaintext", 32'(plaintext), 0);
    chk("s5_key", 32'(key), 0);
    chk("s5_start", 32'(start), 0);
    chk("s5_busy", 32'(busy), 0);
    chk("s5_timeout", 32'(timeout_err), 0);
    tick();
    reset = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    chk("s5_plaintext_new", 32'(plaintext), 32'h0102);
    handshake(1, 1);

    // Scenario 6: done held three cycles
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    tick();
    done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s6_ready_low", 32'(in_ready), 0);
      chk("s6_start_low", 32'(start), 0);
    end
    done = 1'b0;
    tick();
    chk("s6_ready_back", 32'(in_ready), 1);

    // Table-driven vectors
    for (int v = 0; v < 4; v++) begin
      if (tabela[v].carrega) begin
        key_load = 1'b1; key_in = tabela[v].chave;
        tick();
        key_load = 1'b0;
      end
      send_byte(tabela[v].b0, 0);
      if (tabela[v].carrega_ultimo) begin
        key_load = 1'b1; key_in = tabela[v].chave;
      end
      send_byte(tabela[v].b1, 0);
      key_load = 1'b0;
      chk("tab_plaintext", 32'(plaintext), 32'(tabela[v].exp_pt));
      chk("tab_key", 32'(key), 32'(tabela[v].exp_key));
      chk("tab_start", 32'(start), 1);
      handshake(1, 1);
    end

    // Randomized words against the word/key model
    key_model = key;
    for (int w = 0; w < 30; w++) begin
      int d;
      bit ultimo_key;
      logic [K-1:0] k_ultimo;
      bytes_q.delete();
      for (int b = 0; b < N; b++) bytes_q.push_back(8'($urandom));
      word_model = '0;
      foreach (bytes_q[b]) word_model = (word_model << 8) | W'(bytes_q[b]);
      if ($urandom_range(0, 2) == 0) begin
        key_in = K'($urandom);
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        key_model = key_in;
      end
      ultimo_key = ($urandom_range(0, 3) == 0);
      k_ultimo = K'($urandom);
      for (int b = 0; b < N; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        if (b == N - 1 && ultimo_key) begin
          key_load = 1'b1; key_in = k_ultimo;
          key_model = k_ultimo;
        end
        send_byte(bytes_q[b], 0);
        key_load = 1'b0;
      end
      chk("rnd_plaintext", 32'(plaintext), 32'(word_model));
      chk("rnd_key", 32'(key), 32'(key_model));
      chk("rnd_start", 32'(start), 1);
      d = $urandom_range(1, L - 3);
      for (int i = 0; i < d; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          key_load = 1'b1; key_in = K'($urandom);
        end
        tick();
        key_load = 1'b0;
        chk("rnd_start_hold", 32'(start), 1);
        chk("rnd_pt_hold", 32'(plaintext), 32'(word_model));
        chk("rnd_key_hold", 32'(key), 32'(key_model));
      end
      handshake(0, $urandom_range(1, 3));
      chk("rnd_no_timeout", 32'(timeout_err), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
